fft_power_averager: RTL and testbench

//  Downstream of fft_processor. Consumes the bin stream (real/imag/valid/index),

---
 rtl/fft_power_averager_pkg.sv | 25 ++
 rtl/fft_power_averager_acc_ram.sv | 29 ++
 rtl/fft_power_averager.sv | 218 +++++++++++++++++++++
 tb/tb_fft_power_averager.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_power_averager_pkg.sv
// Shared types and width helpers for the FFT bin power averager.
package fft_power_averager_pkg;

    localparam int unsigned FFT_IDX_W = 12;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_IN_FRAME = 1'b1
    } sync_state_t;

    // Position of a bin's frame inside the averaging block, carried down the pipeline.
    typedef struct packed {
        logic is_first;
        logic is_last;
    } bin_tag_t;

    function automatic int unsigned pwr_shift(input int unsigned data_w, input int unsigned pwr_w);
        return 2 * data_w - pwr_w;
    endfunction

    function automatic int unsigned acc_width(input int unsigned pwr_w, input int unsigned avg_log2);
        return pwr_w + avg_log2;
    endfunction

endpackage

// File: rtl/fft_power_averager_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port.
module fft_power_averager_acc_ram #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned WIDTH  = 36
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset so the array maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/fft_power_averager.sv
// Per-bin |X|^2 with block averaging over 2^AVG_LOG2 frames; checks bin order,
// counts frames and emits one averaged spectrum per block.
module fft_power_averager
    import fft_power_averager_pkg::*;
#(
    parameter int unsigned FFT_SIZE   = 4096,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned PWR_WIDTH  = 32,
    parameter int unsigned AVG_LOG2   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] real_in,
    input  logic signed [DATA_WIDTH-1:0] imag_in,
    input  logic                         fft_valid,
    input  logic [FFT_IDX_W-1:0]         fft_index,
    input  logic                         avg_clear,
    output logic [PWR_WIDTH-1:0]         pwr_out,
    output logic                         pwr_valid,
    output logic [FFT_IDX_W-1:0]         pwr_index,
    output logic                         frame_done,
    output logic                         seq_error,
    output logic                         busy
);

    localparam int unsigned ADDR_W = $clog2(FFT_SIZE);
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SHIFT  = pwr_shift(DATA_WIDTH, PWR_WIDTH);
    localparam int unsigned ACC_W  = acc_width(PWR_WIDTH, AVG_LOG2);
    localparam int unsigned CNT_W  = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CNT_W-1:0]     LAST_FRAME = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [FFT_IDX_W-1:0] LAST_BIN   = FFT_IDX_W'(FFT_SIZE - 1);

    sync_state_t            r_state, w_state_nxt;
    logic [FFT_IDX_W-1:0]   r_exp_idx, w_exp_idx_nxt;
    logic                   w_accept, w_mismatch, w_last_bin, w_frame_end;

    logic [CNT_W-1:0]       r_frame_cnt;
    logic                   r_seq_error, r_frame_done, r_busy, r_blk_end;

    logic                         r_s1_vld, r_s2_vld, r_s3_vld;
    logic signed [DATA_WIDTH-1:0] r_s1_re, r_s1_im;
    logic [FFT_IDX_W-1:0]         r_s1_idx, r_s2_idx, r_s3_idx;
    bin_tag_t                     r_s1_tag, r_s2_tag, r_s3_tag;
    logic [PROD_W-1:0]            r_s2_re_sq, r_s2_im_sq;
    logic [PWR_WIDTH-1:0]         r_s3_pw;

    logic signed [PROD_W-1:0] w_re_sq, w_im_sq;
    logic [PROD_W-1:0]        w_psum;
    logic [PWR_WIDTH-1:0]     w_pw, w_avg;
    logic [ACC_W-1:0]         w_ram_rd, w_acc_in, w_acc_sum;
    logic                     w_ram_we;

    logic [PWR_WIDTH-1:0]     r_pwr_out;
    logic [FFT_IDX_W-1:0]     r_pwr_index;
    logic                     r_pwr_valid;

    // Bin-order sync state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_WAIT_SOF;
            r_exp_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_exp_idx <= w_exp_idx_nxt;
        end
    end

    // Accept a frame only from index 0 with strictly consecutive indices.
    always_comb begin
        w_state_nxt   = r_state;
        w_exp_idx_nxt = r_exp_idx;
        w_accept      = 1'b0;
        w_mismatch    = 1'b0;
        w_last_bin    = (fft_index == LAST_BIN);
        if (avg_clear) begin
            w_state_nxt   = ST_WAIT_SOF;
            w_exp_idx_nxt = '0;
        end else if (fft_valid) begin
            unique case (r_state)
                ST_WAIT_SOF: begin
                    if (fft_index == '0) begin
                        w_accept      = 1'b1;
                        w_exp_idx_nxt = FFT_IDX_W'(1);
                        w_state_nxt   = ST_IN_FRAME;
                    end
                end
                ST_IN_FRAME: begin
                    if (fft_index == r_exp_idx) begin
                        w_accept      = 1'b1;
                        w_exp_idx_nxt = r_exp_idx + 1'b1;
                        if (w_last_bin) begin
                            w_state_nxt = ST_WAIT_SOF;
                        end
                    end else begin
                        w_mismatch  = 1'b1;
                        w_state_nxt = ST_WAIT_SOF;
                    end
                end
                default: w_state_nxt = ST_WAIT_SOF;
            endcase
        end
    end

    assign w_frame_end = w_accept & w_last_bin;

    // Frame counter, status flags and pipeline valids; clear flushes everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt  <= '0;
            r_seq_error  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_blk_end    <= 1'b0;
            r_s1_vld     <= 1'b0;
            r_s2_vld     <= 1'b0;
            r_s3_vld     <= 1'b0;
            r_pwr_valid  <= 1'b0;
        end else if (avg_clear) begin
            r_frame_cnt  <= '0;
            r_seq_error  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_blk_end    <= 1'b0;
            r_s1_vld     <= 1'b0;
            r_s2_vld     <= 1'b0;
            r_s3_vld     <= 1'b0;
            r_pwr_valid  <= 1'b0;
        end else begin
            if (w_mismatch) begin
                r_seq_error <= 1'b1;
            end
            if (w_frame_end) begin
                r_frame_cnt <= (r_frame_cnt == LAST_FRAME) ? '0 : r_frame_cnt + 1'b1;
            end
            r_frame_done <= w_frame_end;
            r_s1_vld     <= w_accept;
            r_s2_vld     <= r_s1_vld;
            r_s3_vld     <= r_s2_vld;
            r_pwr_valid  <= r_s3_vld & r_s3_tag.is_last;
            r_blk_end    <= r_s3_vld & r_s3_tag.is_last & (r_s3_idx == LAST_BIN);
            // Busy holds until the final output has left and no new block has begun.
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_blk_end && (r_state == ST_WAIT_SOF) && (r_frame_cnt == '0)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign w_re_sq   = PROD_W'(r_s1_re) * PROD_W'(r_s1_re);
    assign w_im_sq   = PROD_W'(r_s1_im) * PROD_W'(r_s1_im);
    assign w_psum    = r_s2_re_sq + r_s2_im_sq;
    assign w_pw      = PWR_WIDTH'(w_psum >> SHIFT);
    assign w_acc_in  = r_s3_tag.is_first ? '0 : w_ram_rd;
    assign w_acc_sum = w_acc_in + ACC_W'(r_s3_pw);
    assign w_avg     = PWR_WIDTH'(w_acc_sum >> AVG_LOG2);
    assign w_ram_we  = r_s3_vld & ~r_s3_tag.is_last & ~avg_clear;

    // S1 capture, S2 squares, S3 scaled power, S4 output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_re     <= '0;
            r_s1_im     <= '0;
            r_s1_idx    <= '0;
            r_s1_tag    <= '0;
            r_s2_re_sq  <= '0;
            r_s2_im_sq  <= '0;
            r_s2_idx    <= '0;
            r_s2_tag    <= '0;
            r_s3_pw     <= '0;
            r_s3_idx    <= '0;
            r_s3_tag    <= '0;
            r_pwr_out   <= '0;
            r_pwr_index <= '0;
        end else begin
            if (w_accept) begin
                r_s1_re           <= real_in;
                r_s1_im           <= imag_in;
                r_s1_idx          <= fft_index;
                r_s1_tag.is_first <= (r_frame_cnt == '0);
                r_s1_tag.is_last  <= (r_frame_cnt == LAST_FRAME);
            end
            r_s2_re_sq <= $unsigned(w_re_sq);
            r_s2_im_sq <= $unsigned(w_im_sq);
            r_s2_idx   <= r_s1_idx;
            r_s2_tag   <= r_s1_tag;
            r_s3_pw    <= w_pw;
            r_s3_idx   <= r_s2_idx;
            r_s3_tag   <= r_s2_tag;
            if (r_s3_vld && r_s3_tag.is_last && !avg_clear) begin
                r_pwr_out   <= w_avg;
                r_pwr_index <= r_s3_idx;
            end
        end
    end

    fft_power_averager_acc_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (ACC_W)
    ) u_acc_ram (
        .i_clk     (clk),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (r_s3_idx[ADDR_W-1:0]),
        .i_wr_data (w_acc_sum),
        .i_rd_en   (r_s2_vld),
        .i_rd_addr (r_s2_idx[ADDR_W-1:0]),
        .o_rd_data (w_ram_rd)
    );

    assign pwr_out    = r_pwr_out;
    assign pwr_valid  = r_pwr_valid;
    assign pwr_index  = r_pwr_index;
    assign frame_done = r_frame_done;
    assign seq_error  = r_seq_error;
    assign busy       = r_busy;

endmodule

// File: tb/tb_fft_power_averager.sv
// Directed bench: two averagers (4-frame and 16-frame blocks) share one 256-bin stream.
module tb_fft_power_averager;

    localparam int unsigned N = 256;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [23:0] real_in, imag_in;
    logic               fft_valid;
    logic [11:0]        fft_index;
    logic               avg_clear;

    logic [31:0] a_pwr_out, b_pwr_out;
    logic [11:0] a_pwr_index, b_pwr_index;
    logic        a_pwr_valid, a_frame_done, a_seq_error, a_busy;
    logic        b_pwr_valid, b_frame_done, b_seq_error, b_busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat_in [N];
    logic [31:0] exp_a [N];
    int          mon_cnt, mon_next, fd_cnt, b_cnt;
    bit          b_chk;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_power_averager #(.FFT_SIZE(256), .DATA_WIDTH(24), .PWR_WIDTH(32), .AVG_LOG2(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .real_in(real_in), .imag_in(imag_in),
        .fft_valid(fft_valid), .fft_index(fft_index), .avg_clear(avg_clear),
        .pwr_out(a_pwr_out), .pwr_valid(a_pwr_valid), .pwr_index(a_pwr_index),
        .frame_done(a_frame_done), .seq_error(a_seq_error), .busy(a_busy)
    );

    fft_power_averager #(.FFT_SIZE(256), .DATA_WIDTH(24), .PWR_WIDTH(32), .AVG_LOG2(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .real_in(real_in), .imag_in(imag_in),
        .fft_valid(fft_valid), .fft_index(fft_index), .avg_clear(avg_clear),
        .pwr_out(b_pwr_out), .pwr_valid(b_pwr_valid), .pwr_index(b_pwr_index),
        .frame_done(b_frame_done), .seq_error(b_seq_error), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Output monitor: value, index order and 4-cycle latency for every word of dut_a.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_pwr_valid) begin
                check_eq("a_value", 64'(a_pwr_out), 64'(exp_a[a_pwr_index[7:0]]));
                check_eq("a_index", 64'(a_pwr_index), 64'(mon_next));
                check_eq("a_latency", 64'(cyc - lat_in[a_pwr_index[7:0]]), 64'd4);
                mon_next = (mon_next + 1) % N;
                mon_cnt++;
            end
            if (a_frame_done) fd_cnt++;
            if (b_pwr_valid) begin
                b_cnt++;
                if (b_chk) check_eq("b_value", 64'(b_pwr_out), 64'h8000_0000);
            end
        end
    end

    task automatic drive_bin(input logic signed [23:0] re, input logic signed [23:0] im,
                             input int idx, input int gap);
        @(posedge clk); #1;
        real_in   = re;
        imag_in   = im;
        fft_index = 12'(idx);
        fft_valid = 1'b1;
        lat_in[idx] = cyc;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            fft_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            fft_valid = 1'b0;
        end
    endtask

    // mode 0: re=k*256, im=0; mode 1: re=c, im=0; otherwise re=im=c.
    task automatic send_frame(input int mode, input logic signed [23:0] c, input int gap);
        for (int k = 0; k < int'(N); k++) begin
            case (mode)
                0:       drive_bin(24'(k * 256), 24'sd0, k, gap);
                1:       drive_bin(c, 24'sd0, k, gap);
                default: drive_bin(c, c, k, gap);
            endcase
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        fft_valid = 1'b0;
        avg_clear = 1'b1;
        @(posedge clk); #1;
        avg_clear = 1'b0;
    endtask

    task automatic reset_mon();
        mon_cnt  = 0;
        mon_next = 0;
        fd_cnt   = 0;
        b_cnt    = 0;
    endtask

    task automatic set_exp_sq();
        for (int k = 0; k < int'(N); k++) exp_a[k] = 32'(k * k);
    endtask

    task automatic set_exp_const(input logic [31:0] v);
        for (int k = 0; k < int'(N); k++) exp_a[k] = v;
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0; real_in = '0; imag_in = '0; fft_valid = 1'b0;
        fft_index = '0; avg_clear = 1'b0; b_chk = 1'b0;
        for (int k = 0; k < int'(N); k++) lat_in[k] = 0;
        set_exp_sq();
        reset_mon();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pwr_valid", 64'(a_pwr_valid), 64'd0);
        check_eq("rst_pwr_out", 64'(a_pwr_out), 64'd0);
        check_eq("rst_pwr_index", 64'(a_pwr_index), 64'd0);
        check_eq("rst_frame_done", 64'(a_frame_done), 64'd0);
        check_eq("rst_seq_error", 64'(a_seq_error), 64'd0);
        check_eq("rst_busy", 64'(a_busy), 64'd0);
        rst_n = 1'b1;

        // 1: ramp, 4 frames -> k^2
        send_frame(0, '0, 0);
        check_eq("t1_busy_mid", 64'(a_busy), 64'd1);
        send_frame(0, '0, 0);
        send_frame(0, '0, 0);
        check_eq("t1_cnt_before_last", 64'(mon_cnt), 64'd0);
        send_frame(0, '0, 0);
        idle(10);
        check_eq("t1_cnt", 64'(mon_cnt), 64'd256);
        check_eq("t1_seq_error", 64'(a_seq_error), 64'd0);
        check_eq("t1_fd_cnt", 64'(fd_cnt), 64'd4);

        // 2: mixed frames -> 40 every bin
        pulse_clear();
        set_exp_const(32'd40);
        reset_mon();
        send_frame(1, 24'sd1024, 0);
        send_frame(1, 24'sd2048, 0);
        send_frame(1, 24'sd1024, 0);
        send_frame(1, 24'sd2048, 0);
        idle(10);
        check_eq("t2_cnt", 64'(mon_cnt), 64'd256);
        check_eq("t2_fd_cnt", 64'(fd_cnt), 64'd4);
        check_eq("t2_busy_end", 64'(a_busy), 64'd0);

        // 3: full-scale negative corner on both block sizes
        pulse_clear();
        set_exp_const(32'h8000_0000);
        reset_mon();
        b_chk = 1'b1;
        for (int f = 0; f < 16; f++) send_frame(2, 24'sh800000, 0);
        idle(10);
        b_chk = 1'b0;
        check_eq("t3_a_cnt", 64'(mon_cnt), 64'd1024);
        check_eq("t3_b_cnt", 64'(b_cnt), 64'd256);
        check_eq("t3_b_busy", 64'(b_busy), 64'd0);
        check_eq("t3_b_seq_error", 64'(b_seq_error), 64'd0);

        // 4: index skip drops the frame without counting it
        pulse_clear();
        set_exp_sq();
        reset_mon();
        for (int k = 0; k < int'(N); k++) begin
            if (k != 100) drive_bin(24'(k * 256), 24'sd0, k, 0);
        end
        idle(2);
        check_eq("t4_seq_error", 64'(a_seq_error), 64'd1);
        check_eq("t4_fd_dropped", 64'(fd_cnt), 64'd0);
        send_frame(0, '0, 0);
        send_frame(0, '0, 0);
        send_frame(0, '0, 0);
        idle(10);
        check_eq("t4_cnt_3_frames", 64'(mon_cnt), 64'd0);
        send_frame(0, '0, 0);
        idle(10);
        check_eq("t4_cnt", 64'(mon_cnt), 64'd256);
        check_eq("t4_seq_sticky", 64'(a_seq_error), 64'd1);

        // 5: clear mid frame 2 discards the partial block
        pulse_clear();
        check_eq("t5_clear_err", 64'(a_seq_error), 64'd0);
        reset_mon();
        send_frame(1, 24'sd2048, 0);
        send_frame(1, 24'sd2048, 0);
        for (int k = 0; k < 128; k++) drive_bin(24'sd4096, 24'sd0, k, 0);
        pulse_clear();
        for (int k = 128; k < int'(N); k++) drive_bin(24'sd4096, 24'sd0, k, 0);
        idle(10);
        check_eq("t5_cnt_after_clear", 64'(mon_cnt), 64'd0);
        check_eq("t5_seq_error", 64'(a_seq_error), 64'd0);
        check_eq("t5_busy", 64'(a_busy), 64'd0);
        for (int f = 0; f < 4; f++) send_frame(0, '0, 0);
        idle(10);
        check_eq("t5_cnt", 64'(mon_cnt), 64'd256);

        // 6: reset while streaming, then gapped input
        pulse_clear();
        reset_mon();
        for (int f = 0; f < 3; f++) send_frame(0, '0, 0);
        for (int k = 0; k < 200; k++) drive_bin(24'(k * 256), 24'sd0, k, 0);
        check_eq("t6_streamed", 64'(mon_cnt), 64'd195);
        rst_n = 1'b0;
        fft_valid = 1'b0;
        #1;
        check_eq("t6_rst_pwr_valid", 64'(a_pwr_valid), 64'd0);
        check_eq("t6_rst_pwr_out", 64'(a_pwr_out), 64'd0);
        check_eq("t6_rst_pwr_index", 64'(a_pwr_index), 64'd0);
        check_eq("t6_rst_busy", 64'(a_busy), 64'd0);
        check_eq("t6_rst_frame_done", 64'(a_frame_done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_mon();
        for (int f = 0; f < 4; f++) send_frame(0, '0, 2);
        idle(10);
        check_eq("t6_cnt", 64'(mon_cnt), 64'd256);
        check_eq("t6_fd_cnt", 64'(fd_cnt), 64'd4);
        check_eq("t6_busy_end", 64'(a_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
